// File: rtl/fpu_chk_pkg.sv
// Shared constants for the FPU lane result checker: record layout and sweep FSM encoding.
// Lane records are {result[63:0], flags[5:0]} in the low CMP_W bits of each RAM word.
package fpu_chk_pkg;

  localparam int N_LANES = 8;
  localparam int CMP_W   = 70;
  localparam int RAM_W   = 72;
  localparam int RES_MSB = 69;
  localparam int RES_LSB = 6;
  localparam int FLG_MSB = 5;
  localparam int FLG_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/fpu_result_checker_lane_compare.sv
// Combinational compare of every lane's record against lane 0; bit i set when lane i differs.
// Pad bits above the record are deliberately ignored; bit 0 of the mask is always 0.
module lane_compare
  import fpu_chk_pkg::*;
#(
  parameter int LANES  = N_LANES,
  parameter int WORD_W = RAM_W,
  parameter int REC_W  = CMP_W
) (
  input  logic [LANES*WORD_W-1:0] ram_q,
  output logic [LANES-1:0]        lane_mask
);

  localparam int RES_W = RES_MSB - RES_LSB + 1;
  localparam int FLG_W = FLG_MSB - FLG_LSB + 1;

  logic unused_pad;

  always_comb begin
    lane_mask  = '0;
    unused_pad = 1'b0;
    for (int i = 1; i < LANES; i++) begin
      lane_mask[i] = (ram_q[i*WORD_W+RES_LSB +: RES_W] != ram_q[RES_LSB +: RES_W]) ||
                     (ram_q[i*WORD_W+FLG_LSB +: FLG_W] != ram_q[FLG_LSB +: FLG_W]);
    end
    for (int i = 0; i < LANES; i++) begin
      unused_pad = unused_pad ^ (^ram_q[i*WORD_W+REC_W +: WORD_W-REC_W]);
    end
  end

endmodule

// File: rtl/fpu_result_checker.sv
// Sweeps all result RAMs address by address, compares each lane to lane 0 and keeps pass/count/first error.
// done arrives LAST_ADDR+RD_LAT+3 clocks after start; start is ignored unless idle.
module fpu_result_checker #(
  parameter int N_LANES   = fpu_chk_pkg::N_LANES,
  parameter int ADDR_W    = 12,
  parameter int RAM_W     = fpu_chk_pkg::RAM_W,
  parameter int CMP_W     = fpu_chk_pkg::CMP_W,
  parameter int LAST_ADDR = 4095,
  parameter int RD_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_LANES*RAM_W-1:0] ram_q,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ADDR_W:0]          mismatch_count,
  output logic [ADDR_W-1:0]        first_err_addr,
  output logic [N_LANES-1:0]       first_err_lanes
);

  import fpu_chk_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  chk_state_t state, state_nxt;

  logic [RD_LAT-1:0]  dl_vld;
  logic [ADDR_W-1:0]  dl_addr [RD_LAT];
  logic               cmp_vld;
  logic [N_LANES-1:0] cmp_mask;
  logic [ADDR_W-1:0]  cmp_addr;
  logic [N_LANES-1:0] lane_mask;
  logic               sweep_start;
  logic               issue;
  logic               drained;

  assign sweep_start = (state == IDLE) && start;
  assign issue       = (state == SWEEP);
  assign drained     = !(|dl_vld) && !cmp_vld;

  lane_compare #(
    .LANES  (N_LANES),
    .WORD_W (RAM_W),
    .REC_W  (CMP_W)
  ) u_lane_compare (
    .ram_q     (ram_q),
    .lane_mask (lane_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SWEEP;
      SWEEP:   if (ram_addr == LAST) state_nxt = DRAIN;
      DRAIN:   if (drained) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SWEEP) || (state == DRAIN);
    done = (state == DONE);
  end

  // The {valid, addr} delay line matches RAM read latency so each emerging entry lines up with ram_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr        <= '0;
      dl_vld          <= '0;
      for (int k = 0; k < RD_LAT; k++) dl_addr[k] <= '0;
      cmp_vld         <= 1'b0;
      cmp_mask        <= '0;
      cmp_addr        <= '0;
      mismatch_count  <= '0;
      first_err_addr  <= '0;
      first_err_lanes <= '0;
      pass            <= 1'b0;
    end else begin
      for (int k = RD_LAT - 1; k > 0; k--) begin
        dl_vld[k]  <= dl_vld[k-1];
        dl_addr[k] <= dl_addr[k-1];
      end
      dl_vld[0]  <= issue;
      dl_addr[0] <= ram_addr;

      cmp_vld  <= dl_vld[RD_LAT-1];
      cmp_mask <= lane_mask;
      cmp_addr <= dl_addr[RD_LAT-1];

      if (sweep_start) begin
        ram_addr        <= '0;
        mismatch_count  <= '0;
        first_err_addr  <= '0;
        first_err_lanes <= '0;
        pass            <= 1'b0;
      end else if (issue && (ram_addr != LAST)) begin
        ram_addr <= ram_addr + 1'b1;
      end

      // A zero count means nothing has been latched yet this sweep, and saturation never returns to zero.
      if (cmp_vld && (|cmp_mask)) begin
        if (mismatch_count != '1) mismatch_count <= mismatch_count + 1'b1;
        if (mismatch_count == '0) begin
          first_err_addr  <= cmp_addr;
          first_err_lanes <= cmp_mask;
        end
      end

      if ((state == DRAIN) && drained) pass <= (mismatch_count == '0);
    end
  end

endmodule

// File: tb/tb_fpu_result_checker.sv
// Directed bench for fpu_result_checker: behavioural RAM lanes, scoreboard of expected sweep results.
// Three instances cover RD_LAT 1/2/3 with full-size and 16-entry sweeps.
module tb_fpu_result_checker;

  localparam int AW    = 12;
  localparam int NL    = 8;
  localparam int RW    = 72;
  localparam int LAST0 = 4095;
  localparam int LAST1 = 15;

  typedef struct {
    int d;
    bit pass;
    int cnt;
    int fa;
    int fl;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   mode;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;
  exp_t sbq[$];

  logic           start_v [3];
  logic [AW-1:0]  addr_v  [3];
  logic           busy_v  [3];
  logic           done_v  [3];
  logic           pass_v  [3];
  logic [AW:0]    cnt_v   [3];
  logic [AW-1:0]  fa_v    [3];
  logic [NL-1:0]  fl_v    [3];
  logic [NL*RW-1:0] q_v   [3];

  logic [AW-1:0] ap0;
  logic [AW-1:0] ap1 [2];
  logic [AW-1:0] ap2 [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RW-1:0] rec(input int m, input int lane, input logic [AW-1:0] a);
    logic [63:0] r;
    logic [5:0]  f;
    logic [1:0]  u;
    r = (64'h9E3779B97F4A7C15 * {52'd0, a}) ^ 64'hA5A5_0000_0000_5A5A;
    f = a[5:0] ^ 6'h2A;
    u = 2'b00;
    case (m)
      1: if (lane == 5 && a == 12'h123) r[40] = ~r[40];
      2: begin
        if (a == 12'h010 && (lane == 2 || lane == 7)) f[2] = ~f[2];
        if (a == 12'h800 && lane == 3) r[0] = ~r[0];
      end
      3: u = 2'(lane) ^ a[1:0];
      4: if (lane == 1) r[63] = ~r[63];
      5: if (lane == 6 && a == 12'd15) f[0] = ~f[0];
      default: ;
    endcase
    return {u, r, f};
  endfunction

  function automatic logic [NL*RW-1:0] build(input int m, input logic [AW-1:0] a);
    logic [NL*RW-1:0] q;
    for (int l = 0; l < NL; l++) q[l*RW +: RW] = rec(m, l, a);
    return q;
  endfunction

  // Behavioural RAMs: address registered, then RD_LAT-1 further stages.
  always @(posedge clk) begin
    ap0    <= addr_v[0];
    ap1[0] <= addr_v[1];
    ap1[1] <= ap1[0];
    ap2[0] <= addr_v[2];
    ap2[1] <= ap2[0];
    ap2[2] <= ap2[1];
  end

  always_comb begin
    q_v[0] = build(mode, ap0);
    q_v[1] = build(mode, ap1[1]);
    q_v[2] = build(mode, ap2[2]);
  end

  fpu_result_checker #(.LAST_ADDR(LAST0), .RD_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .ram_q(q_v[0]), .ram_addr(addr_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .mismatch_count(cnt_v[0]),
    .first_err_addr(fa_v[0]), .first_err_lanes(fl_v[0]));

  fpu_result_checker #(.LAST_ADDR(LAST1), .RD_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .ram_q(q_v[1]), .ram_addr(addr_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .mismatch_count(cnt_v[1]),
    .first_err_addr(fa_v[1]), .first_err_lanes(fl_v[1]));

  fpu_result_checker #(.LAST_ADDR(LAST1), .RD_LAT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .ram_q(q_v[2]), .ram_addr(addr_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .mismatch_count(cnt_v[2]),
    .first_err_addr(fa_v[2]), .first_err_lanes(fl_v[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input int d);
    chk("rst_addr",  addr_v[d], 0);
    chk("rst_busy",  busy_v[d], 0);
    chk("rst_done",  done_v[d], 0);
    chk("rst_pass",  pass_v[d], 0);
    chk("rst_count", cnt_v[d],  0);
    chk("rst_faddr", fa_v[d],   0);
    chk("rst_flane", fl_v[d],   0);
  endtask

  task automatic sweep(input int d, input int m, input bit ep, input int ecnt, input int efa,
                       input int efl, input bit mid, input bit sid);
    exp_t e;
    exp_t got;
    int   c0;
    bit   seen;
    mode  = m;
    e.d    = d;
    e.pass = ep;
    e.cnt  = ecnt;
    e.fa   = efa;
    e.fl   = efl;
    e.lat  = ((d == 0) ? LAST0 : LAST1) + (d + 1) + 3;
    sbq.push_back(e);
    @(negedge clk);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    c0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < e.lat + 20 && !seen; i++) begin
      @(negedge clk);
      start_v[d] = 1'b0;
      if (done_v[d]) seen = 1'b1;
      else if (mid && addr_v[d] == 12'h200) start_v[d] = 1'b1;
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      got = sbq.pop_front();
      chk("sb_dut",     d,            got.d);
      chk("latency",    cyc - c0,     got.lat);
      chk("pass",       pass_v[d],    got.pass);
      chk("count",      cnt_v[d],     got.cnt);
      chk("first_addr", fa_v[d],      got.fa);
      chk("first_lane", fl_v[d],      got.fl);
      chk("busy_done",  busy_v[d],    0);
      if (sid) start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      chk("done_pulse", done_v[d], 0);
      chk("idle_busy",  busy_v[d], 0);
      chk("pass_hold",  pass_v[d], got.pass);
    end
  endtask

  initial begin
    bit hit;
    int ndone;
    rst_n = 1'b0;
    mode  = 0;
    for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals(0);
    rst_n = 1'b1;

    sweep(0, 0, 1, 0, 0,      0,    0, 1);
    sweep(0, 1, 0, 1, 'h123,  'h20, 0, 0);
    sweep(0, 2, 0, 2, 'h010,  'h84, 0, 0);
    sweep(0, 3, 1, 0, 0,      0,    0, 0);

    // Abort a sweep that already holds a mismatch, so the reset values are distinguishable.
    mode = 2;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (addr_v[0] == 12'h400) hit = 1'b1;
    end
    chk("abort_reach", hit, 1);
    chk("abort_pre_count", cnt_v[0], 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals(0);
    start_v[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_v[0] = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    chk("abort_busy", busy_v[0], 0);
    chk("abort_no_done", ndone, 0);

    sweep(0, 0, 1, 0,  0,  0,     1, 0);
    sweep(1, 4, 0, 16, 0,  'h02,  0, 0);
    sweep(1, 5, 0, 1,  15, 'h40,  0, 0);
    sweep(2, 5, 0, 1,  15, 'h40,  0, 0);

    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
